// File: rtl/fht_pkg.sv
// Shared types and helpers for the FHT address sequencer.
package fht_pkg;

  localparam int unsigned N_LOG2_DEF   = 8;
  localparam int unsigned PIPE_LAT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Reverses the low n_log2 bits of addr; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] addr, input int unsigned n_log2);
    logic [31:0] r;
    r = '0;
    for (int unsigned b = 0; b < n_log2; b++) begin
      r[b] = addr[n_log2-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_addr_dly.sv
// Resettable PIPE_LAT-deep shift register carrying the write strobe and the two write addresses.
module fht_addr_dly #(
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [AW-1:0] addr_0,
  input  logic [AW-1:0] addr_1,
  output logic          dly_valid,
  output logic [AW-1:0] dly_addr_0,
  output logic [AW-1:0] dly_addr_1
);

  localparam int unsigned W = 1 + 2 * AW;

  logic [W-1:0] line [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        line[i] <= '0;
      end
    end else begin
      line[0] <= {valid, addr_0, addr_1};
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        line[i] <= line[i-1];
      end
    end
  end

  assign {dly_valid, dly_addr_0, dly_addr_1} = line[PIPE_LAT-1];

endmodule

// File: rtl/fht_addr_gen.sv
// Stage/address sequencer for the in-place radix-2 FHT butterfly (fht_but).
// Optional bit-reversal copy stage is enabled by defining FHT_ADDR_BITREV_EN.
module fht_addr_gen
  import fht_pkg::*;
#(
  parameter int unsigned N_LOG2   = N_LOG2_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                          iCLK,
  input  logic                          iRESET,
  input  logic                          iSTART,
  output logic                          oBUSY,
  output logic                          oDONE,
  output logic [$clog2(N_LOG2+1)-1:0]   oSTAGE,
  output logic                          oBANK,
  output logic                          oRD_VALID,
  output logic [N_LOG2-1:0]             oRD_ADDR_0,
  output logic [N_LOG2-1:0]             oRD_ADDR_1,
  output logic [N_LOG2-1:0]             oRD_ADDR_2,
  output logic [N_LOG2-1:0]             oROM_ADDR,
  output logic                          oWR_EN,
  output logic [N_LOG2-1:0]             oWR_ADDR_0,
  output logic [N_LOG2-1:0]             oWR_ADDR_1
);

  localparam int unsigned AW = N_LOG2;
  localparam int unsigned SW = $clog2(N_LOG2 + 1);
  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [AW-1:0] HALF_LAST = AW'((1 << (N_LOG2 - 1)) - 1);

`ifdef FHT_ADDR_BITREV_EN
  localparam logic [SW-1:0] FIRST_STAGE = '0;
`else
  localparam logic [SW-1:0] FIRST_STAGE = SW'(1);
`endif

  state_t        state, state_n;
  logic [SW-1:0] stage, stage_n;
  logic          bank, bank_n;
  logic [AW-1:0] idx, idx_n, last;
  logic [DW-1:0] dcnt, dcnt_n;

  logic [SW-1:0] sm1, rsh;
  logic [AW-1:0] h, l, b, k;
  logic [AW-1:0] rd0, rd1, rd2, rom, wr0, wr1;
  logic          rd_valid;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= IDLE;
      stage <= '0;
      bank  <= 1'b0;
      idx   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      bank  <= bank_n;
      idx   <= idx_n;
      dcnt  <= dcnt_n;
    end
  end

  always_comb begin
`ifdef FHT_ADDR_BITREV_EN
    last = (stage == '0) ? '1 : HALF_LAST;
`else
    last = HALF_LAST;
`endif
  end

  always_comb begin
    state_n = state;
    stage_n = stage;
    bank_n  = bank;
    idx_n   = idx;
    dcnt_n  = dcnt;
    case (state)
      IDLE: begin
        if (iSTART) begin
          state_n = RUN;
          stage_n = FIRST_STAGE;
          bank_n  = 1'b0;
          idx_n   = '0;
          dcnt_n  = '0;
        end
      end
      RUN: begin
        if (idx == last) begin
          state_n = DRAIN;
          idx_n   = '0;
          dcnt_n  = '0;
        end else begin
          idx_n = idx + AW'(1);
        end
      end
      DRAIN: begin
        // Drain equals the pipeline depth so the last write of a stage lands before the bank flips.
        if (dcnt == DW'(PIPE_LAT - 1)) begin
          if (stage == SW'(N_LOG2)) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            stage_n = stage + SW'(1);
            bank_n  = ~bank;
          end
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        stage_n = '0;
        bank_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Butterfly index math; modulo-2^N_LOG2 wrap makes b+L-k correct even when L = N.
  always_comb begin
    sm1 = stage - SW'(1);
    rsh = SW'(N_LOG2) - stage;
    h   = AW'(1) << sm1;
    l   = h << 1;
    b   = (idx >> sm1) << stage;
    k   = idx & (h - AW'(1));
    rd0 = '0;
    rd1 = '0;
    rd2 = '0;
    rom = '0;
    wr0 = '0;
    wr1 = '0;
    rd_valid = (state == RUN);
    if (rd_valid) begin
`ifdef FHT_ADDR_BITREV_EN
      if (stage == '0) begin
        rd0 = AW'(bitrev(32'(idx), N_LOG2));
        wr0 = idx;
        wr1 = idx;
      end else begin
`else
      begin
`endif
        rd0 = b + k;
        rd1 = b + h + k;
        rd2 = (k == '0) ? (b + h) : (b + l - k);
        rom = k << rsh;
        wr0 = rd0;
        wr1 = rd1;
      end
    end
  end

  assign oBUSY      = (state == RUN) || (state == DRAIN);
  assign oDONE      = (state == DONE);
  assign oSTAGE     = stage;
  assign oBANK      = bank;
  assign oRD_VALID  = rd_valid;
  assign oRD_ADDR_0 = rd0;
  assign oRD_ADDR_1 = rd1;
  assign oRD_ADDR_2 = rd2;
  assign oROM_ADDR  = rom;

  fht_addr_dly #(
    .PIPE_LAT (PIPE_LAT),
    .AW       (AW)
  ) u_dly (
    .clk        (iCLK),
    .rst        (iRESET),
    .valid      (rd_valid),
    .addr_0     (wr0),
    .addr_1     (wr1),
    .dly_valid  (oWR_EN),
    .dly_addr_0 (oWR_ADDR_0),
    .dly_addr_1 (oWR_ADDR_1)
  );

endmodule

// File: tb/tb_fht_addr_gen.sv
// Scoreboard bench for fht_addr_gen at N_LOG2=3, PIPE_LAT=3 (honours FHT_ADDR_BITREV_EN).
module tb_fht_addr_gen;

  localparam int unsigned NL = 3;
  localparam int unsigned PL = 3;

`ifdef FHT_ADDR_BITREV_EN
  localparam int DONE_C = 33;
  localparam logic BANK0 = 1'b1;
`else
  localparam int DONE_C = 22;
  localparam logic BANK0 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          iRESET, iSTART;
  logic          oBUSY, oDONE, oBANK, oRD_VALID, oWR_EN;
  logic [1:0]    oSTAGE;
  logic [NL-1:0] oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR, oWR_ADDR_0, oWR_ADDR_1;

  always #5 clk = ~clk;

  fht_addr_gen #(
    .N_LOG2   (NL),
    .PIPE_LAT (PL)
  ) dut (
    .iCLK       (clk),
    .iRESET     (iRESET),
    .iSTART     (iSTART),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE),
    .oSTAGE     (oSTAGE),
    .oBANK      (oBANK),
    .oRD_VALID  (oRD_VALID),
    .oRD_ADDR_0 (oRD_ADDR_0),
    .oRD_ADDR_1 (oRD_ADDR_1),
    .oRD_ADDR_2 (oRD_ADDR_2),
    .oROM_ADDR  (oROM_ADDR),
    .oWR_EN     (oWR_EN),
    .oWR_ADDR_0 (oWR_ADDR_0),
    .oWR_ADDR_1 (oWR_ADDR_1)
  );

  typedef struct {
    int         tag;
    logic [2:0] a0, a1, a2, rom;
    logic       bank;
    logic [1:0] stage;
  } rd_t;

  typedef struct {
    int         tag;
    logic [2:0] w0, w1;
    logic       bank;
  } wr_t;

  // {a0, a1, a2, rom} for stages 1..3, four reads each.
  localparam logic [11:0] RD_TAB [12] = '{
    {3'd0, 3'd1, 3'd1, 3'd0}, {3'd2, 3'd3, 3'd3, 3'd0}, {3'd4, 3'd5, 3'd5, 3'd0}, {3'd6, 3'd7, 3'd7, 3'd0},
    {3'd0, 3'd2, 3'd2, 3'd0}, {3'd1, 3'd3, 3'd3, 3'd2}, {3'd4, 3'd6, 3'd6, 3'd0}, {3'd5, 3'd7, 3'd7, 3'd2},
    {3'd0, 3'd4, 3'd4, 3'd0}, {3'd1, 3'd5, 3'd7, 3'd1}, {3'd2, 3'd6, 3'd6, 3'd2}, {3'd3, 3'd7, 3'd5, 3'd3}
  };
  localparam logic [2:0] BR_TAB [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  rd_t rd_q [$];
  wr_t wr_q [$];
  int  done_q [$];
  bit  busy_map [int];

  int ecount = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) ecount <= ecount + 1;

  // Cycle c of a run started at edge s0 is sampled with ecount == s0 + c - 1.
  task automatic push_run(input int s0);
    int c;
    rd_t r;
    wr_t w;
    logic [11:0] e;
    c = 1;
`ifdef FHT_ADDR_BITREV_EN
    for (int j = 0; j < 8; j++) begin
      r = '{tag: s0 + c - 1, a0: BR_TAB[j], a1: 3'd0, a2: 3'd0, rom: 3'd0, bank: 1'b0, stage: 2'd0};
      w = '{tag: s0 + c - 1 + PL, w0: 3'(j), w1: 3'(j), bank: 1'b0};
      rd_q.push_back(r);
      wr_q.push_back(w);
      c++;
    end
    c += PL;
`endif
    for (int st = 0; st < 3; st++) begin
      for (int i = 0; i < 4; i++) begin
        e = RD_TAB[st*4 + i];
        r = '{tag: s0 + c - 1, a0: e[11:9], a1: e[8:6], a2: e[5:3], rom: e[2:0],
              bank: BANK0 ^ st[0], stage: 2'(st + 1)};
        w = '{tag: s0 + c - 1 + PL, w0: e[11:9], w1: e[8:6], bank: BANK0 ^ st[0]};
        rd_q.push_back(r);
        wr_q.push_back(w);
        c++;
      end
      c += PL;
    end
    for (int cc = 1; cc < DONE_C; cc++) busy_map[s0 + cc - 1] = 1'b1;
    done_q.push_back(s0 + DONE_C - 1);
  endtask

  task automatic check_zero(input string name);
    logic [24:0] got;
    got = {oBUSY, oDONE, oSTAGE, oBANK, oRD_VALID, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2,
           oROM_ADDR, oWR_EN, oWR_ADDR_0, oWR_ADDR_1};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s: outputs got %h want 0", name, got);
    end
  endtask

  task automatic start_and_wait(output int s);
    @(negedge clk);
    iSTART = 1'b1;
    @(posedge clk);
    #1;
    s = ecount;
    push_run(s);
    iSTART = 1'b0;
  endtask

  // Monitor: pops expected records whenever the DUT presents a read, write or done.
  always @(negedge clk) begin
    if (!iRESET) begin
      if (oRD_VALID) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: cycle %0d got a=%0d,%0d,%0d rom=%0d, nothing expected",
                   ecount, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR);
        end else begin
          rd_t x;
          x = rd_q.pop_front();
          if (x.tag != ecount || {oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR, oBANK, oSTAGE}
              !== {x.a0, x.a1, x.a2, x.rom, x.bank, x.stage}) begin
            errors++;
            $display("FAIL rd: got cyc=%0d a=%0d,%0d,%0d rom=%0d bank=%0d stage=%0d want cyc=%0d a=%0d,%0d,%0d rom=%0d bank=%0d stage=%0d",
                     ecount, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oROM_ADDR, oBANK, oSTAGE,
                     x.tag, x.a0, x.a1, x.a2, x.rom, x.bank, x.stage);
          end
        end
      end
      if (oWR_EN) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: cycle %0d got w=%0d,%0d, nothing expected",
                   ecount, oWR_ADDR_0, oWR_ADDR_1);
        end else begin
          wr_t y;
          y = wr_q.pop_front();
          if (y.tag != ecount || {oWR_ADDR_0, oWR_ADDR_1, oBANK} !== {y.w0, y.w1, y.bank}) begin
            errors++;
            $display("FAIL wr: got cyc=%0d w=%0d,%0d bank=%0d want cyc=%0d w=%0d,%0d bank=%0d",
                     ecount, oWR_ADDR_0, oWR_ADDR_1, oBANK, y.tag, y.w0, y.w1, y.bank);
          end
        end
      end
      if (oDONE) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: cycle %0d got done, nothing expected", ecount);
        end else begin
          int d;
          d = done_q.pop_front();
          if (d != ecount) begin
            errors++;
            $display("FAIL done: got cycle %0d want cycle %0d", ecount, d);
          end
        end
      end
      checks++;
      if (oBUSY !== busy_map.exists(ecount)) begin
        errors++;
        $display("FAIL busy: cycle %0d got %0d want %0d", ecount, oBUSY, busy_map.exists(ecount));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    iRESET = 1'b1;
    iSTART = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    iRESET = 1'b0;
    repeat (2) @(negedge clk);

    // Plain run
    start_and_wait(s);
    repeat (DONE_C + 3) @(negedge clk);
    check_zero("idle_after_run");

    // Asynchronous reset during cycle 9
    start_and_wait(s);
    repeat (8) @(posedge clk);
    #1;
    iRESET = 1'b1;
    #1;
    check_zero("async_reset");
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    busy_map.delete();
    @(negedge clk);
    iRESET = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (oWR_EN !== 1'b0) begin
        errors++;
        $display("FAIL no_write_after_reset: got wr_en=%0d want 0", oWR_EN);
      end
    end

    // Fresh run after reset reproduces the sequence
    start_and_wait(s);
    repeat (DONE_C + 3) @(negedge clk);

    // Start held high: second run only accepted on the edge after DONE
    @(negedge clk);
    iSTART = 1'b1;
    @(posedge clk);
    #1;
    s = ecount;
    push_run(s);
    push_run(s + DONE_C + 1);
    repeat (DONE_C + 1) @(posedge clk);
    #1;
    iSTART = 1'b0;
    repeat (DONE_C + 4) @(negedge clk);
    check_zero("idle_after_held_start");

    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_pending: got %0d outstanding reads want 0", rd_q.size());
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL wr_pending: got %0d outstanding writes want 0", wr_q.size());
    end
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL done_pending: got %0d outstanding done want 0", done_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
